key_event_queue: RTL
====================

// Module: key_event_queue
// PURPOSE
//  Consumer end of the debounced-key user interface (key_flag / key_value, active-high one-hot-ish).
//  Encodes each key_flag pulse into a binary key code and queues it in a small synchronous FIFO.
//  Presents queued events downstream on a valid/ready handshake, so that slow consumers such as
//  UART, LCD menu or CPU polling logic lose no key presses. Reports overflow via a sticky flag.
// PARAMETERS
//  KEY_WIDTH   4  width of key_value; number of keys
//  CODE_W      2  width of evt_code; must satisfy 2**CODE_W >= KEY_WIDTH
//  FIFO_DEPTH  4  queue entries; power of two, >= 2
//  PTR_W       2  log2(FIFO_DEPTH)
// PORTS
//  clk          in   1          system clock; the only clock
//  rst_n        in   1          asynchronous active-low reset
//  key_flag     in   1          one-cycle strobe from the debouncer; key_value is valid in the same cycle
//  key_value    in   KEY_WIDTH  pressed-key vector, bit=1 means pressed
//  evt_valid    out  1          head event available
//  evt_ready    in   1          consumer accepts head event
//  evt_code     out  CODE_W     index of the lowest set bit of the queued key_value
//  evt_multi    out  1          queued key_value had more than one bit set
//  fifo_count   out  PTR_W+1    number of entries held, 0..FIFO_DEPTH
//  overflow     out  1          sticky; an event was dropped because the queue was full
//  clr_overflow in   1          synchronous clear of overflow
// BEHAVIOUR
//  - Reset: evt_valid=0, evt_code=0, evt_multi=0, fifo_count=0, overflow=0, pointers=0. Reset
//    mid-operation discards all queued entries immediately.
//  - Push request = key_flag && (key_value != 0). key_flag with key_value==0 is ignored: no push,
//    no overflow.
//  - Encode: code = index of the lowest set bit; multi = popcount(key_value) > 1. Entry is
//    {multi, code}, CODE_W+1 bits.
//  - Pop = evt_valid && evt_ready. evt_valid = (fifo_count != 0). Show-ahead: evt_code/evt_multi
//    always reflect the head entry. evt_code/evt_multi hold their last value when the queue is empty.
//  - Latency: key_flag at edge N -> entry written at N -> evt_valid=1 in cycle N+1 if the queue
//    was empty.
//  - Push while not full: accept; count+1, or unchanged if a pop occurs in the same cycle.
//  - Push while full with simultaneous pop: accept; the pop frees the slot and count stays at
//    FIFO_DEPTH.
//  - Push while full without pop: drop the event, set overflow, leave the queue unchanged.
//  - Pop while empty: impossible, because evt_valid=0. evt_ready is don't-care when empty.
//  - Pointers wrap modulo FIFO_DEPTH. fifo_count is a separate PTR_W+1 counter, never derived
//    from the pointers.
//  - overflow: a set event and clr_overflow in the same cycle -> set wins (overflow=1).
//  - evt_code/evt_multi must be stable while evt_valid=1 and evt_ready=0.
// STRUCTURE
//  - Shared include key_defs.vh: KEY_WIDTH default, CODE_W default, entry width macro.
//  - Top key_event_queue: encoder (combinational, lowest-set-bit + multi detect), push/pop
//    control, overflow flag.
//  - One sub-module: key_evt_fifo, a generic sync FIFO (WIDTH, DEPTH, PTR_W) with wr_en, rd_en,
//    dout (show-ahead), count, full, empty. Async active-low reset on pointers and count;
//    storage array is not reset.
// TESTING
//  - Reset mid-operation: 3 entries queued, assert rst_n=0 -> next cycle fifo_count=0,
//    evt_valid=0, overflow=0.
//  - Single press: key_flag=1 with key_value=4'b0100, evt_ready=0 -> next cycle evt_valid=1,
//    evt_code=2, evt_multi=0, fifo_count=1.
//  - Multi/zero: key_value=4'b1010 -> evt_code=1, evt_multi=1. key_flag with key_value=0 ->
//    fifo_count unchanged.
//  - Ordering: push codes 0,3,1 with evt_ready=0, then hold evt_ready=1 -> codes pop as 0,3,1,
//    then evt_valid=0.
//  - Overflow: 5 pushes with evt_ready=0 -> fifo_count=4, overflow=1, head still the first code.
//    clr_overflow=1 -> overflow=0.
//  - Full boundary: queue full, push with evt_ready=1 in the same cycle -> fifo_count stays 4,
//    overflow stays 0. Assert clr_overflow together with a dropped push -> overflow=1.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared definitions for the key event queue.
// Default geometry and entry layout helpers.
package key_event_queue_pkg;

  localparam int KEY_WIDTH_DEF  = 4;
  localparam int CODE_W_DEF     = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PTR_W_DEF      = 2;

  // Queued entry is {multi, code}
  function automatic int entry_w(input int code_w);
    return code_w + 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Generic synchronous show-ahead FIFO.
// Pointers and count reset; storage is not.
module key_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage write, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy kept as its own counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Encodes debounced key strobes and queues them
// for a valid/ready consumer, with sticky overflow.
module key_event_queue
  import key_event_queue_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int CODE_W     = CODE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PTR_W      = PTR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_flag,
  input  logic [KEY_WIDTH-1:0] key_value,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CODE_W-1:0]    evt_code,
  output logic                 evt_multi,
  output logic [PTR_W:0]       fifo_count,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int EW = entry_w(CODE_W);

  logic [CODE_W-1:0] enc_code;
  logic              enc_multi;
  logic              push_req;
  logic              pop;
  logic              wr_en;
  logic              ov_set;
  logic              full;
  logic              empty;
  logic [EW-1:0]     head;
  logic [EW-1:0]     hold_q;

  // Lowest set bit wins; scan from the top down
  always_comb begin
    enc_code = '0;
    for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
      if (key_value[i]) enc_code = CODE_W'(i);
    end
  end

  // More than one bit set if clearing the lowest leaves any
  assign enc_multi =
    |(key_value & (key_value - KEY_WIDTH'(1)));

  assign push_req = key_flag && (key_value != '0);
  assign pop      = !empty && evt_ready;
  assign wr_en    = push_req && (!full || pop);
  assign ov_set   = push_req && full && !pop;

  key_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data ({enc_multi, enc_code}),
    .rd_en   (pop),
    .dout    (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  // Remember the head so outputs hold once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else if (!empty) hold_q <= head;
  end

  assign evt_valid = !empty;
  assign {evt_multi, evt_code} = empty ? hold_q : head;

  // Sticky overflow; a new drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (ov_set) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule
